// File: rtl/fp_dot_seq.sv
// Operand sequencer for the 5-bit FP MAC: buffers A/B operand pairs, clears the MAC,
// streams LEN pairs, drains the pipeline with zero pairs and captures the result.
module fp_dot_seq #(
   parameter int unsigned W       = 5,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned AW      = 4,
   parameter int unsigned CLR_CYC = 2,
   parameter int unsigned MAC_LAT = 4
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [W-1:0]  i_wr_a,
   input  logic [W-1:0]  i_wr_b,
   input  logic [AW:0]   i_len,
   input  logic          i_start,
   output logic          o_busy,
   output logic [W-1:0]  o_mac_a,
   output logic [W-1:0]  o_mac_b,
   output logic          o_mac_clr,
   input  logic [W-1:0]  i_mac_out,
   output logic [W-1:0]  o_result,
   output logic          o_result_valid
);

   localparam int unsigned LW    = AW + 1;
   localparam int unsigned CMAX  = (CLR_CYC > MAC_LAT) ? CLR_CYC : MAC_LAT;
   localparam int unsigned CW    = $clog2(CMAX) + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [W-1:0]  r_mem_a [DEPTH];
   logic [W-1:0]  r_mem_b [DEPTH];

   logic [2:0]    r_state, w_state;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [AW-1:0] r_idx, w_idx;
   logic [LW-1:0] r_len, w_len;
   logic          r_busy, w_busy;
   logic          r_clr, w_clr;
   logic [W-1:0]  r_a, w_a;
   logic [W-1:0]  r_b, w_b;
   logic [W-1:0]  r_result, w_result;
   logic          r_valid, w_valid;
   logic          w_wr;
   logic [AW-1:0] w_idx_nxt;
   logic          w_last_pair;

   assign w_wr        = (r_state == S_IDLE) && i_wr_en;
   assign w_idx_nxt   = r_idx + AW'(1);
   assign w_last_pair = (LW'(r_idx) == (r_len - LW'(1)));

   // Operand buffers are storage only; contents are undefined until written.
   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_mem_a[i_wr_addr] <= i_wr_a;
         r_mem_b[i_wr_addr] <= i_wr_b;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_len    <= '0;
         r_busy   <= 1'b0;
         r_clr    <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_idx    <= w_idx;
         r_len    <= w_len;
         r_busy   <= w_busy;
         r_clr    <= w_clr;
         r_a      <= w_a;
         r_b      <= w_b;
         r_result <= w_result;
         r_valid  <= w_valid;
      end
   end

   // Next-state logic also computes the next output values so every output is a flop.
   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_idx    = r_idx;
      w_len    = r_len;
      w_busy   = 1'b0;
      w_clr    = 1'b0;
      w_a      = '0;
      w_b      = '0;
      w_result = r_result;
      w_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_len   = (i_len > LW'(DEPTH)) ? LW'(DEPTH) : i_len;
               w_cnt   = '0;
               w_state = S_CLEAR;
               w_busy  = 1'b1;
               w_clr   = 1'b1;
            end
         end
         S_CLEAR: begin
            w_busy = 1'b1;
            if (r_cnt == CW'(CLR_CYC - 1)) begin
               w_cnt = '0;
               if (r_len == '0) begin
                  w_state = S_DRAIN;
               end else begin
                  w_state = S_STREAM;
                  w_idx   = '0;
                  w_a     = r_mem_a[0];
                  w_b     = r_mem_b[0];
               end
            end else begin
               w_cnt = r_cnt + CW'(1);
               w_clr = 1'b1;
            end
         end
         S_STREAM: begin
            w_busy = 1'b1;
            if (w_last_pair) begin
               w_state = S_DRAIN;
               w_cnt   = '0;
            end else begin
               w_idx = w_idx_nxt;
               w_a   = r_mem_a[w_idx_nxt];
               w_b   = r_mem_b[w_idx_nxt];
            end
         end
         S_DRAIN: begin
            if (r_cnt == CW'(MAC_LAT - 1)) begin
               w_result = i_mac_out;
               w_valid  = 1'b1;
               w_state  = S_DONE;
            end else begin
               w_cnt  = r_cnt + CW'(1);
               w_busy = 1'b1;
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   assign o_busy         = r_busy;
   assign o_mac_a        = r_a;
   assign o_mac_b        = r_b;
   assign o_mac_clr      = r_clr;
   assign o_result       = r_result;
   assign o_result_valid = r_valid;

endmodule

// File: tb/tb_fp_dot_seq.sv
// Self-checking bench for fp_dot_seq with a small pipelined stand-in MAC and a result scoreboard.
module tb_fp_dot_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_wr_en;
   logic [3:0] i_wr_addr;
   logic [4:0] i_wr_a, i_wr_b;
   logic [4:0] i_len;
   logic       i_start;
   logic       o_busy, o_mac_clr, o_result_valid;
   logic [4:0] o_mac_a, o_mac_b, o_result;
   logic [4:0] mac_out;

   int checks = 0;
   int errors = 0;
   int n_valid = 0;
   logic [4:0] q[$];
   logic [4:0] ma [16];
   logic [4:0] mb [16];

   always #5 clk = ~clk;

   fp_dot_seq dut (
      .i_clk(clk), .i_reset(rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
      .i_wr_a(i_wr_a), .i_wr_b(i_wr_b), .i_len(i_len), .i_start(i_start),
      .o_busy(o_busy), .o_mac_a(o_mac_a), .o_mac_b(o_mac_b), .o_mac_clr(o_mac_clr),
      .i_mac_out(mac_out), .o_result(o_result), .o_result_valid(o_result_valid)
   );

   // Stand-in MAC: two product stages then accumulate, modulo-32 arithmetic.
   logic [4:0] p1 = 5'd0, p2 = 5'd0, acc = 5'd0;
   always @(posedge clk) begin
      if (o_mac_clr) begin
         p1 <= 5'd0; p2 <= 5'd0; acc <= 5'd0;
      end else begin
         p1  <= 5'(o_mac_a * o_mac_b);
         p2  <= p1;
         acc <= acc + p2;
      end
   end
   assign mac_out = acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] dot(input int l);
      int n = (l > 16) ? 16 : l;
      logic [4:0] s = 5'd0;
      for (int i = 0; i < n; i++) s = s + 5'(ma[i] * mb[i]);
      return s;
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1 && o_result_valid === 1'b1) begin
         n_valid++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL result_unexpected: observed %0d expected no result", o_result);
         end else begin
            chk("result", 32'(o_result), 32'(q.pop_front()));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int addr, input logic [4:0] a, input logic [4:0] b);
      i_wr_en = 1'b1; i_wr_addr = 4'(addr); i_wr_a = a; i_wr_b = b;
      ma[addr] = a; mb[addr] = b;
      tick;
      i_wr_en = 1'b0;
   endtask

   // Runs one sequence from start; optional illegal write / extra start at given cycles.
   task automatic run_seq(input int l, input int bad_wr_cyc, input int restart_cyc, input string tag);
      int cyc = 0;
      int busy_bad = 0;
      int n = (l > 16) ? 16 : l;
      i_len = 5'(l);
      i_start = 1'b1;
      q.push_back(dot(l));
      do begin
         tick;
         cyc++;
         i_start = (cyc == restart_cyc);
         i_wr_en = (cyc == bad_wr_cyc);
         if (o_result_valid !== 1'b1 && o_busy !== 1'b1) busy_bad++;
      end while (o_result_valid !== 1'b1 && cyc < 60);
      i_start = 1'b0;
      i_wr_en = 1'b0;
      chk({tag, "_latency"}, 32'(cyc), 32'(1 + 2 + n + 4));
      chk({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
      chk({tag, "_busy_done"}, 32'(o_busy), 32'd0);
   endtask

   initial begin
      int nv;
      rst_n = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_a = '0; i_wr_b = '0;
      i_len = '0; i_start = 1'b0;
      repeat (3) tick;
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_clr", 32'(o_mac_clr), 32'd0);
      chk("rst_mac_a", 32'(o_mac_a), 32'd0);
      chk("rst_result", 32'(o_result), 32'd0);
      chk("rst_valid", 32'(o_result_valid), 32'd0);
      rst_n = 1'b1;
      tick;

      // Sequence order with per-cycle checks
      wr(0, 5'b01001, 5'b00101);
      wr(1, 5'b01010, 5'b00110);
      wr(2, 5'b00111, 5'b01000);
      i_len = 5'd3; i_start = 1'b1;
      q.push_back(dot(3));
      for (int c = 1; c <= 11; c++) begin
         tick;
         i_start = 1'b0;
         if (c <= 2) begin
            chk("seq_clr_hi", 32'(o_mac_clr), 32'd1);
            chk("seq_clr_a", 32'(o_mac_a), 32'd0);
         end else if (c <= 5) begin
            chk("seq_clr_lo", 32'(o_mac_clr), 32'd0);
            chk("seq_a", 32'(o_mac_a), 32'(ma[c-3]));
            chk("seq_b", 32'(o_mac_b), 32'(mb[c-3]));
         end else if (c <= 9) begin
            chk("seq_drain_a", 32'(o_mac_a), 32'd0);
            chk("seq_drain_b", 32'(o_mac_b), 32'd0);
            chk("seq_drain_valid", 32'(o_result_valid), 32'd0);
         end else if (c == 10) begin
            chk("seq_valid", 32'(o_result_valid), 32'd1);
            chk("seq_result", 32'(o_result), 32'd1);
         end else begin
            chk("seq_valid_pulse", 32'(o_result_valid), 32'd0);
            chk("seq_result_hold", 32'(o_result), 32'd1);
         end
      end

      // Reset mid-STREAM at idx 3
      for (int i = 0; i < 16; i++) wr(i, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
      i_len = 5'd8; i_start = 1'b1;
      q.push_back(dot(8));
      for (int c = 1; c <= 6; c++) begin
         tick;
         i_start = 1'b0;
      end
      chk("mid_a_idx3", 32'(o_mac_a), 32'(ma[3]));
      rst_n = 1'b0;
      #1;
      void'(q.pop_back());
      chk("mid_rst_busy", 32'(o_busy), 32'd0);
      chk("mid_rst_a", 32'(o_mac_a), 32'd0);
      chk("mid_rst_b", 32'(o_mac_b), 32'd0);
      chk("mid_rst_clr", 32'(o_mac_clr), 32'd0);
      chk("mid_rst_result", 32'(o_result), 32'd0);
      chk("mid_rst_valid", 32'(o_result_valid), 32'd0);
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      run_seq(8, -1, -1, "after_rst");
      tick;

      // Zero A operands, full length
      for (int i = 0; i < 16; i++) wr(i, 5'd0, 5'($urandom_range(1, 31)));
      run_seq(16, -1, -1, "zero_ops");
      chk("zero_ops_result", 32'(o_result), 32'd0);
      tick;

      // len = 0
      for (int i = 0; i < 16; i++) wr(i, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
      run_seq(0, -1, -1, "len0");
      chk("len0_result", 32'(o_result), 32'd0);
      tick;

      // Start while busy
      nv = n_valid;
      run_seq(5, -1, 4, "start_busy");
      repeat (20) tick;
      chk("start_busy_pulses", 32'(n_valid - nv), 32'd1);

      // Write blocked during STREAM, then rerun
      i_wr_addr = 4'd0; i_wr_a = ~ma[0]; i_wr_b = ~mb[0];
      run_seq(5, 4, -1, "wr_blocked");
      tick;
      run_seq(5, -1, -1, "wr_blocked_rerun");

      // Back-to-back: start in the IDLE cycle right after DONE
      tick;
      run_seq(7, -1, -1, "b2b_first");
      tick;
      run_seq(2, -1, -1, "b2b_second");
      tick;

      // Start and write in the same IDLE cycle
      i_wr_en = 1'b1; i_wr_addr = 4'd1; i_wr_a = 5'd13; i_wr_b = 5'd11;
      ma[1] = 5'd13; mb[1] = 5'd11;
      run_seq(3, -1, -1, "start_wr_same");
      tick;

      // Clamp len 17 to 16
      run_seq(16, -1, -1, "len16");
      tick;
      run_seq(17, -1, -1, "len17");
      tick;
      tick;
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_dot_seq.md
Name: fp_dot_seq

Overview:
- Upstream operand sequencer for the 5-bit floating-point MAC (fp_mac).
- Holds two small operand buffers (A = activations, B = weights), loaded by the host one pair per cycle.
- On start: clears the MAC, streams LEN operand pairs into it, then feeds zero pairs while the MAC pipeline drains.
- Captures the accumulated MAC output and presents it with a one-cycle valid pulse. Owns all MAC sequencing so the host only sees load, start and result.

Parameters:
- W, 5: operand/result width. Encoding is a 5-bit FP format in which 5'b00000 is +0.
- DEPTH, 16: entries per operand buffer.
- AW, 4: buffer address width; DEPTH = 2**AW.
- CLR_CYC, 2: cycles mac_clr is held high before streaming.
- MAC_LAT, 4: zero-feed drain cycles after the last operand pair; must be ≥ MAC input-to-out latency.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset (low = reset asserted)
- wr_en  in  1  buffer write strobe
- wr_addr  in  AW  buffer write address
- wr_a  in  W  operand A written to A[wr_addr]
- wr_b  in  W  operand B written to B[wr_addr]
- len  in  AW+1  dot-product length, sampled with start, valid range 0..DEPTH
- start  in  1  single-cycle start request
- busy  out  1  sequence in progress
- mac_a  out  W  MAC operand a, registered
- mac_b  out  W  MAC operand b, registered
- mac_clr  out  1  drives the MAC synchronous active-high reset
- mac_out  in  W  MAC accumulator output
- result  out  W  captured dot-product result
- result_valid  out  1  one-cycle pulse when result updates

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; busy, mac_clr, result_valid = 0; mac_a, mac_b, result = 0; idx and counters = 0.
  - Buffer contents are not reset and must be rewritten before use.
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - wr_en writes A[wr_addr] and B[wr_addr] at the clock edge.
  - start = 1 latches len into len_q, then goes to CLEAR.
  - mac_a and mac_b hold 0.
- CLEAR:
  - mac_clr = 1 for exactly CLR_CYC cycles; mac_a, mac_b = 0.
  - Then go to STREAM, or to DRAIN if len_q = 0.
- STREAM:
  - Lasts len_q cycles; idx runs 0..len_q-1.
  - mac_a = A[idx], mac_b = B[idx], mac_clr = 0.
  - Entries are presented in ascending address order, one pair per cycle with no bubbles.
  - After idx = len_q-1, go to DRAIN.
- DRAIN:
  - Lasts MAC_LAT cycles with mac_a, mac_b = 0. The MAC accumulates every cycle, so 0×0 keeps the sum unchanged.
  - At the end of the last DRAIN cycle, result <= mac_out; go to DONE.
- DONE:
  - result_valid = 1 for exactly one cycle, busy = 0, then go to IDLE.
  - result holds its value until the next capture or reset.
- busy = 1 in CLEAR, STREAM and DRAIN only.
- Latency: with start high in cycle 0, result_valid is high in cycle 1 + CLR_CYC + len + MAC_LAT.
  - Defaults with len = 3: cycle 10.
  - len = 0: cycle 7, result = MAC value after clear (expected 00000).
- Boundary conditions:
  - start while busy or in DONE: ignored, no queuing.
  - wr_en while state ≠ IDLE: ignored, buffer unchanged.
  - start and wr_en in the same IDLE cycle: the write completes; the stream reads the updated entry.
  - len > DEPTH: clamped to DEPTH.
  - len = DEPTH: idx reaches DEPTH-1 with no wrap; no entry is read twice.
  - Back-to-back: start may be accepted in the IDLE cycle immediately after DONE. The MAC is re-cleared each run, so there is no carry-over.
  - reset low mid-sequence: immediate return to IDLE with all outputs 0. The MAC sees mac_clr = 0 with zero operands, so its accumulator holds; the next run's CLEAR flushes it.

Test Plan:
- Reset: assert reset low mid-STREAM (len = 8, idx = 3) -> busy, mac_a, mac_b, mac_clr, result, result_valid all 0 immediately; state IDLE; a subsequent start runs normally.
- Sequence order: load A = {01001, 01010, 00111}, B = {00101, 00110, 01000}, len = 3, start at cycle 0 -> mac_clr high cycles 1–2; (mac_a, mac_b) = the three pairs in cycles 3–5; zeros in cycles 6–9; result_valid in cycle 10 with result = the reference-model MAC output.
- Zero operands: len = 16, all A = 00000 -> result = 00000 in cycle 23; busy high in cycles 1–22.
- len = 0 -> no STREAM cycles; result_valid in cycle 7; result = 00000.
- Start while busy: second start pulse in cycle 4 ignored -> exactly one result_valid pulse.
- Write blocked during busy: wr_en to addr 0 during STREAM ignored -> rerun with same len gives the identical result.
- Back-to-back: start in the cycle after DONE -> accepted; the second result is independent of the first.
- Clamp: len = 17 behaves exactly as len = 16.
